// File: rtl/audio_codec_config.sv
`default_nettype none
// ============================================================================
// audio_codec_config : writes the WM8731 power-up register table over I2C.
// Revision 1.0
// ============================================================================
module audio_codec_config #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         I2C_FREQ  = 100_000,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] word_idx,
  output logic       i2c_sclk,
  output logic       i2c_sdat_oe,
  input  logic       i2c_sdat_i
);

  localparam int         QDIV      = CLK_FREQ / (4 * I2C_FREQ);
  localparam int         QW        = $clog2(QDIV);
  localparam logic [3:0] LAST_WORD = 4'd10;
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_ph;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic [3:0]      r_retry;
  logic            r_nack;
  logic            r_sda_m, r_sda_s;
  logic            w_qtick, w_last, w_accept;
  logic            w_sclk, w_oe;
  logic [15:0]     w_word;
  logic [7:0]      w_tx_byte;

  assign w_qtick  = (r_qcnt == QW'(QDIV - 1));
  assign w_last   = w_qtick && (r_ph == 2'd3);
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    case (word_idx)
      4'd0:    w_word = 16'h1E00;
      4'd1:    w_word = 16'h0017;
      4'd2:    w_word = 16'h0217;
      4'd3:    w_word = 16'h0479;
      4'd4:    w_word = 16'h0679;
      4'd5:    w_word = 16'h0812;
      4'd6:    w_word = 16'h0A00;
      4'd7:    w_word = 16'h0C00;
      4'd8:    w_word = 16'h0E0A;
      4'd9:    w_word = 16'h1000;
      4'd10:   w_word = 16'h1201;
      default: w_word = 16'h0000;
    endcase
  end

  always_comb begin
    case (r_byte)
      2'd0:    w_tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    w_tx_byte = w_word[15:8];
      default: w_tx_byte = w_word[7:0];
    endcase
  end

  // Bus levels are decoded here and registered below so the pins are glitch-free.
  always_comb begin
    w_state_nxt = r_state;
    w_sclk      = 1'b1;
    w_oe        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_START;
      end
      S_START: begin
        w_sclk = (r_ph != 2'd3);
        w_oe   = (r_ph != 2'd0);
        if (w_last) w_state_nxt = S_BIT;
      end
      S_BIT: begin
        w_sclk = r_ph[1];
        w_oe   = ~w_tx_byte[r_bit];
        if (w_last && (r_bit == 3'd0)) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_sclk = r_ph[1];
        if (w_last) w_state_nxt = (!r_nack && (r_byte != 2'd2)) ? S_BIT : S_STOP;
      end
      S_STOP: begin
        w_sclk = (r_ph != 2'd0);
        w_oe   = (r_ph != 2'd3);
        if (w_last) w_state_nxt = (r_nack && (r_retry == RETRY_MAX)) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (w_last) w_state_nxt = (!r_nack && (word_idx == LAST_WORD)) ? S_IDLE : S_START;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_idx    <= 4'd0;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
      r_qcnt      <= '0;
      r_ph        <= 2'd0;
      r_bit       <= 3'd7;
      r_byte      <= 2'd0;
      r_retry     <= 4'd0;
      r_nack      <= 1'b0;
      r_sda_m     <= 1'b1;
      r_sda_s     <= 1'b1;
    end else begin
      r_sda_m     <= i2c_sdat_i;
      r_sda_s     <= r_sda_m;
      i2c_sclk    <= w_sclk;
      i2c_sdat_oe <= w_oe;
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_ph   <= 2'd0;
      end else begin
        r_qcnt <= w_qtick ? '0 : r_qcnt + 1'b1;
        if (w_qtick) r_ph <= r_ph + 2'd1;
      end
      if (w_accept) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
        word_idx <= 4'd0;
        r_retry  <= 4'd0;
        r_byte   <= 2'd0;
        r_bit    <= 3'd7;
        r_nack   <= 1'b0;
      end
      case (r_state)
        S_BIT: begin
          if (w_last) r_bit <= r_bit - 3'd1;
        end
        S_ACK: begin
          if (w_qtick && (r_ph == 2'd2)) r_nack <= r_sda_s;
          if (w_last && !r_nack) r_byte <= r_byte + 2'd1;
        end
        S_STOP: begin
          if (w_last && r_nack && (r_retry == RETRY_MAX)) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_last) begin
            r_byte <= 2'd0;
            r_bit  <= 3'd7;
            if (r_nack) begin
              r_retry <= r_retry + 4'd1;
              r_nack  <= 1'b0;
            end else if (word_idx == LAST_WORD) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              word_idx <= word_idx + 4'd1;
              r_retry  <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
